idct_transpose_mem: RTL and testbench

- 8x8 transpose buffer between the row and column 1-D IDCT passes.
- Write phase (mode=0) stores one 16-bit coefficient per cycle in row-major order.
- Read phase (mode=1) returns the block in column-major order, one word per cycle.
- Outputs carry a mode tag and a valid flag for the downstream column pass.

---
 rtl/idct_transpose_mem_if.sv | 25 ++
 rtl/idct_transpose_mem.sv | 80 ++++++++
 tb/tb_idct_transpose_mem.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/idct_transpose_mem_if.sv
// idct_transpose_mem_if: data/control bundle between a row IDCT pass and the transpose buffer.
// Carries no state and adds no latency; there is no backpressure, because enable alone gates each transfer.
// Signals: data_write, enable and mode go into the buffer; data_read, tmpmode and readenable come back out.
interface idct_transpose_mem_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] data_write;
  logic              enable;
  logic              mode;
  logic [DATA_W-1:0] data_read;
  logic              tmpmode;
  logic              readenable;

  // master: the side that drives coefficients and control (the row pass or a testbench).
  modport master (
    output data_write, enable, mode,
    input  data_read, tmpmode, readenable
  );

  // slave: the transpose buffer itself.
  modport slave (
    input  data_write, enable, mode,
    output data_read, tmpmode, readenable
  );
endinterface

// File: rtl/idct_transpose_mem.sv
// idct_transpose_mem: DIM x DIM transpose buffer. Row-major words go in; column-major words come out.
// Latency: data_read, readenable and tmpmode are registered and appear one cycle after the read edge.
// No backpressure: the buffer accepts or returns one word on every enabled cycle; enable=0 stalls everything.
// Ports:
//   clk, rst      - rising-edge clock and synchronous active-high reset. Reset clears the whole array.
//   bus (slave)   - data_write/enable/mode in, data_read/tmpmode/readenable out.
// Optional feature: define TRANSPOSE_EN to read in transposed (column-major) order.
// Without it, reads are row-major and the block works as a plain replay buffer.
module idct_transpose_mem #(
  parameter int DATA_W = 16,
  parameter int DIM    = 8   // must be a power of two, >= 2
) (
  input  logic                 clk,
  input  logic                 rst,
  idct_transpose_mem_if.slave  bus
);

  localparam int LOG   = $clog2(DIM);
  localparam int AW    = 2 * LOG;
  localparam int DEPTH = DIM * DIM;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_cnt;
  logic [AW-1:0]     r_rd_cnt;
  logic              r_prev_mode;
  logic [DATA_W-1:0] r_data_read;
  logic              r_readenable;
  logic              r_tmpmode;

  logic [AW-1:0]     w_wr_idx;
  logic [AW-1:0]     w_rd_idx;
  logic [AW-1:0]     w_rd_addr;

  // The first cycle after a phase change starts at index 0. The counter of the new phase
  // has already been cleared by the other phase, and prev_mode makes that explicit here.
  // An enable gap leaves prev_mode unchanged, so a gap never restarts a phase.
  assign w_wr_idx = r_prev_mode ? '0 : r_wr_cnt;
  assign w_rd_idx = r_prev_mode ? r_rd_cnt : '0;

`ifdef TRANSPOSE_EN
  // Swap the column and row fields of the read index. This walks the block column by column.
  assign w_rd_addr = {w_rd_idx[LOG-1:0], w_rd_idx[AW-1:LOG]};
`else
  assign w_rd_addr = w_rd_idx;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_cnt     <= '0;
      r_rd_cnt     <= '0;
      r_prev_mode  <= 1'b0;
      r_data_read  <= '0;
      r_readenable <= 1'b0;
      r_tmpmode    <= 1'b0;
    end else begin
      r_readenable <= bus.enable & bus.mode;
      r_tmpmode    <= bus.mode;
      if (bus.enable) begin
        r_prev_mode <= bus.mode;
        if (!bus.mode) begin
          r_mem[w_wr_idx] <= bus.data_write;
          r_wr_cnt        <= w_wr_idx + AW'(1);
          r_rd_cnt        <= '0;
        end else begin
          r_data_read <= r_mem[w_rd_addr];
          r_rd_cnt    <= w_rd_idx + AW'(1);
          r_wr_cnt    <= '0;
        end
      end
    end
  end

  assign bus.data_read  = r_data_read;
  assign bus.readenable = r_readenable;
  assign bus.tmpmode    = r_tmpmode;

endmodule

// File: tb/tb_idct_transpose_mem.sv
// tb_idct_transpose_mem: directed and random stimulus for idct_transpose_mem, checked against an array model.
// Latency: outputs are sampled 1 time unit after every rising edge.
// Backpressure: none; the bench drives one input set per cycle.
module tb_idct_transpose_mem;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  idct_transpose_mem_if #(.DATA_W(16)) bus ();

  idct_transpose_mem #(.DATA_W(16), .DIM(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: 64-word block plus the two running indices.
  logic [15:0] m_mem [64];
  int          m_wr, m_rd;
  logic [15:0] m_dr;
  logic        m_re, m_tm;
  logic [15:0] blk [64];

  // k-th word of the read sequence, taken as a position in the written row-major block.
  function automatic int ord(input int k);
`ifdef TRANSPOSE_EN
    return (k % 8) * 8 + (k / 8);
`else
    return k;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic en, input logic md, input logic [15:0] wd, input string tag);
    bus.enable     = en;
    bus.mode       = md;
    bus.data_write = wd;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 64; i++) m_mem[i] = '0;
      m_wr = 0; m_rd = 0; m_dr = '0; m_re = 1'b0; m_tm = 1'b0;
    end else begin
      m_re = en & md;
      m_tm = md;
      if (en && !md) begin
        m_mem[m_wr] = wd;
        m_wr = (m_wr + 1) % 64;
        m_rd = 0;
      end else if (en && md) begin
        m_dr = m_mem[ord(m_rd)];
        m_rd = (m_rd + 1) % 64;
        m_wr = 0;
      end
    end
    #1;
    check({tag, ".readenable"}, 32'(bus.readenable), 32'(m_re));
    check({tag, ".tmpmode"},    32'(bus.tmpmode),    32'(m_tm));
    check({tag, ".data_read"},  32'(bus.data_read),  32'(m_dr));
  endtask

  task automatic write_blk(input string tag);
    for (int i = 0; i < 64; i++) cyc(1'b1, 1'b0, blk[i], tag);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) m_mem[i] = '0;
    m_wr = 0; m_rd = 0; m_dr = '0; m_re = 1'b0; m_tm = 1'b0;
    rst = 1'b1;
    bus.enable = 1'b0; bus.mode = 1'b0; bus.data_write = '0;

    // Reset state
    cyc(1'b0, 1'b0, 16'h0, "reset");
    check("reset.dr0", 32'(bus.data_read), 32'h0);
    rst = 1'b0;

    // Transpose order, then wrap: 64 + 128 reads after a full write of 0..63
    for (int i = 0; i < 64; i++) blk[i] = 16'(i);
    write_blk("wr0");
    for (int k = 0; k < 192; k++) begin
      cyc(1'b1, 1'b1, 16'h0, "rd0");
      check("order", 32'(bus.data_read), 32'(ord(k % 64)));
      check("valid", 32'({bus.readenable, bus.tmpmode}), 32'h3);
    end

    // Enable gap in the middle of a read of a random block
    for (int i = 0; i < 64; i++) blk[i] = 16'($urandom);
    write_blk("wr_gap");
    for (int k = 0; k < 10; k++) cyc(1'b1, 1'b1, 16'h0, "rd_gap_a");
    for (int g = 0; g < 3; g++) begin
      cyc(1'b0, 1'b1, 16'h0, "gap");
      check("gap.hold", 32'(bus.data_read), 32'(blk[ord(9)]));
      check("gap.re0", 32'(bus.readenable), 32'h0);
    end
    for (int k = 10; k < 64; k++) begin
      cyc(1'b1, 1'b1, 16'h0, "rd_gap_b");
      check("gap.resume", 32'(bus.data_read), 32'(blk[ord(k)]));
    end

    // Reset mid-read at read index 20
    for (int i = 0; i < 64; i++) blk[i] = 16'(i + 1);
    write_blk("wr_rst");
    for (int k = 0; k < 20; k++) cyc(1'b1, 1'b1, 16'h0, "rd_rst");
    rst = 1'b1;
    cyc(1'b1, 1'b1, 16'h0, "rst_mid");
    check("rst_mid.all0", 32'({bus.data_read, bus.readenable, bus.tmpmode}), 32'h0);
    rst = 1'b0;
    for (int k = 0; k < 64; k++) begin
      cyc(1'b1, 1'b1, 16'h0, "rd_zero");
      check("rd_zero", 32'(bus.data_read), 32'h0);
    end

    // Back-to-back blocks A (100+i) and B (200+i)
    for (int i = 0; i < 64; i++) blk[i] = 16'(100 + i);
    write_blk("wrA");
    for (int k = 0; k < 64; k++) begin
      cyc(1'b1, 1'b1, 16'h0, "rdA");
      check("blkA", 32'(bus.data_read), 32'(100 + ord(k)));
    end
    for (int i = 0; i < 64; i++) blk[i] = 16'(200 + i);
    write_blk("wrB");
    for (int k = 0; k < 64; k++) begin
      cyc(1'b1, 1'b1, 16'h0, "rdB");
      check("blkB", 32'(bus.data_read), 32'(200 + ord(k)));
    end

    // Random traffic: partial phases, enable gaps and occasional resets
    begin
      logic md;
      md = 1'b0;
      for (int c = 0; c < 600; c++) begin
        if ($urandom_range(0, 15) == 0) md = ~md;
        rst = ($urandom_range(0, 99) == 0);
        cyc(($urandom_range(0, 3) != 0), md, 16'($urandom), "rand");
      end
      rst = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
